// File: rtl/pin_uart_pkg.sv
// pin_uart_pkg
// Shared definitions for the board UART link. The transmitter uses them now,
// and the future receiver will import them too.
//   uart_state_t    : frame-level FSM states
//   UART_DATA_BITS  : payload bits per frame
//   UART_IDLE_LEVEL : level of the serial line between frames
//   even_parity()   : parity bit that makes the count of ones in data+parity even
package pin_uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen
// Counts clock cycles within one serial bit time.
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   ena      : 0 freezes the counter
//   clear    : hold the counter at 0 (used while the line is idle)
//   bit_done : one-cycle pulse on the last cycle of each bit time
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic clear,
  output logic bit_done
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;
  logic          w_at_last;

  assign w_at_last = (r_cnt == LAST);

  // Wraps at LAST so the counter never runs past one bit time, even when
  // CLKS_PER_BIT is not a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (ena) begin
      if (clear || w_at_last) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign bit_done = ena && !clear && w_at_last;

endmodule

// File: rtl/pin_uart_tx.sv
// pin_uart_tx
// 8N1 serial transmitter (optional even parity), LSB first, fixed integer
// clocks per bit. The serial line is driven straight from a flop.
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset; aborts any frame in flight
//   ena       : 1 run, 0 freeze every state element (tx holds its level)
//   tx_data   : byte to send, sampled only on accept
//   tx_valid  : request to send tx_data
//   tx_ready  : block can accept a byte this cycle
//   tx        : serial line, idle high
//   busy      : a frame is in progress
//   dbg_state : current FSM state for observation
//
// Handshake: a byte is accepted on a rising edge where tx_valid, tx_ready and
// ena are all high. tx_ready is high only in IDLE with ena high. A request made
// while busy is dropped, not queued; the requester holds tx_valid until it sees
// tx_ready. tx_data may change freely after the accept edge.
module pin_uart_tx
  import pin_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ena,
  input  logic [UART_DATA_BITS-1:0] tx_data,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  output logic                      tx,
  output logic                      busy,
  output uart_state_t               dbg_state
);

  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  uart_state_t               r_state;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic                      r_parity;
  logic [2:0]                r_bit_cnt;
  logic                      r_tx;

  uart_state_t               w_state_nxt;
  logic [UART_DATA_BITS-1:0] w_shift_nxt;
  logic                      w_parity_nxt;
  logic [2:0]                w_bit_cnt_nxt;
  logic                      w_tx_nxt;
  logic                      w_accept;
  logic                      w_baud_clear;
  logic                      w_bit_done;

  // Holding the baud counter clear while idle means it starts from 0 on the
  // first start-bit cycle without a separate clear pulse on accept.
  assign w_baud_clear = (r_state == IDLE);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .clear    (w_baud_clear),
    .bit_done (w_bit_done)
  );

  assign tx_ready  = (r_state == IDLE) && ena;
  assign busy      = (r_state != IDLE);
  assign tx        = r_tx;
  assign dbg_state = r_state;
  assign w_accept  = tx_valid && tx_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_bit_cnt <= '0;
      r_tx      <= UART_IDLE_LEVEL;
    end else if (ena) begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_parity  <= w_parity_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_tx      <= w_tx_nxt;
    end
  end

  // Next-state logic also computes the line level for the next cycle, so the
  // registered tx changes on the same edge as the state it belongs to.
  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_parity_nxt  = r_parity;
    w_bit_cnt_nxt = r_bit_cnt;
    w_tx_nxt      = r_tx;
    case (r_state)
      IDLE: begin
        w_tx_nxt = UART_IDLE_LEVEL;
        if (w_accept) begin
          w_shift_nxt   = tx_data;
          w_parity_nxt  = even_parity(tx_data);
          w_bit_cnt_nxt = '0;
          w_state_nxt   = START;
          w_tx_nxt      = 1'b0;
        end
      end
      START: begin
        if (w_bit_done) begin
          w_state_nxt = DATA;
          w_tx_nxt    = r_shift[0];
        end
      end
      DATA: begin
        if (w_bit_done) begin
          w_shift_nxt   = r_shift >> 1;
          w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          if (r_bit_cnt == LAST_BIT) begin
            if (PARITY_EN) begin
              w_state_nxt = PARITY;
              w_tx_nxt    = r_parity;
            end else begin
              w_state_nxt = STOP;
              w_tx_nxt    = UART_IDLE_LEVEL;
            end
          end else begin
            // Next data bit is the one that becomes bit 0 after this shift.
            w_tx_nxt = r_shift[1];
          end
        end
      end
      PARITY: begin
        if (w_bit_done) begin
          w_state_nxt = STOP;
          w_tx_nxt    = UART_IDLE_LEVEL;
        end
      end
      STOP: begin
        if (w_bit_done) begin
          w_state_nxt = IDLE;
          w_tx_nxt    = UART_IDLE_LEVEL;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_tx_nxt    = UART_IDLE_LEVEL;
      end
    endcase
  end

endmodule

// File: tb/tb_pin_uart_tx.sv
// tb_pin_uart_tx
// Two transmitters share the clock, reset, enable and data bus: u_dut0 without
// parity, u_dut1 with even parity. Each frame is predicted as a per-cycle list
// of line levels built from the byte value, and the serial line is compared
// against it every cycle on the falling edge.
module tb_pin_uart_tx;
  import pin_uart_pkg::*;

  localparam int CPB = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ena;
  logic [7:0]  tx_data;
  logic        tx_valid0, tx_valid1;
  logic        tx_ready0, tx_ready1;
  logic        tx0, tx1;
  logic        busy0, busy1;
  uart_state_t dbg0, dbg1;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc    = 0;
  logic [0:0]  exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  pin_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .ena(ena), .tx_data(tx_data), .tx_valid(tx_valid0),
    .tx_ready(tx_ready0), .tx(tx0), .busy(busy0), .dbg_state(dbg0)
  );

  pin_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .ena(ena), .tx_data(tx_data), .tx_valid(tx_valid1),
    .tx_ready(tx_ready1), .tx(tx1), .busy(busy1), .dbg_state(dbg1)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic f_tx(input int sel);
    return (sel != 0) ? tx1 : tx0;
  endfunction
  function automatic logic f_busy(input int sel);
    return (sel != 0) ? busy1 : busy0;
  endfunction
  function automatic logic f_ready(input int sel);
    return (sel != 0) ? tx_ready1 : tx_ready0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Line level for every cycle of the frame: start 0, data LSB first,
  // optional even-parity bit, stop 1; each bit lasts CPB cycles.
  task automatic build_frame(input logic [7:0] b, input bit pe);
    int ones;
    int v;
    ones = 0;
    exp_q.delete();
    for (int k = 0; k < CPB; k++) exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      v = (int'(b) >> i) & 1;
      ones += v;
      for (int k = 0; k < CPB; k++) exp_q.push_back(1'(v));
    end
    if (pe) begin
      for (int k = 0; k < CPB; k++) exp_q.push_back(1'(ones % 2));
    end
    for (int k = 0; k < CPB; k++) exp_q.push_back(1'b1);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_valid(input int sel, input logic v);
    if (sel != 0) tx_valid1 = v;
    else          tx_valid0 = v;
  endtask

  task automatic wait_ready(input int sel);
    int n;
    n = 0;
    while (f_ready(sel) !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait_bound", 32'(n < 200), 32'd1);
  endtask

  // Returns on the falling edge of the first start-bit cycle.
  task automatic start_frame(input int sel, input logic [7:0] b, input bit hold,
                             output int unsigned t_acc);
    wait_ready(sel);
    tx_data = b;
    set_valid(sel, 1'b1);
    @(posedge clk);
    t_acc = cyc;
    @(negedge clk);
    if (!hold) set_valid(sel, 1'b0);
    tx_data = 8'($urandom);
  endtask

  // Checks every cycle of the frame, then the idle cycle after it.
  // stall_at / pulse_at = -1 disables the enable stall / stray request.
  task automatic check_frame(input int sel, input logic [7:0] b,
                             input int stall_at, input int stall_len, input int pulse_at);
    int          f;
    int unsigned t0;
    int          stalled;
    build_frame(b, sel != 0);
    f       = exp_q.size();
    t0      = cyc;
    stalled = 0;
    for (int i = 1; i <= f; i++) begin
      if (i > 1) @(negedge clk);
      chk1("tx_bit", f_tx(sel), exp_q[i-1]);
      chk1("busy_frame", f_busy(sel), 1'b1);
      chk1("ready_frame", f_ready(sel), 1'b0);
      if (i == pulse_at) begin
        tx_data = 8'h3C;
        set_valid(sel, 1'b1);
      end
      if (i == pulse_at + 1) set_valid(sel, 1'b0);
      if (i == stall_at) begin
        ena = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          @(negedge clk);
          chk1("tx_stall_hold", f_tx(sel), exp_q[i-1]);
          chk1("ready_stall", f_ready(sel), 1'b0);
          chk1("busy_stall", f_busy(sel), 1'b1);
        end
        ena     = 1'b1;
        stalled = stall_len;
      end
    end
    @(negedge clk);
    chk("frame_len", 32'(cyc - t0), 32'(f + stalled));
    chk1("tx_idle", f_tx(sel), 1'b1);
    chk1("busy_idle", f_busy(sel), 1'b0);
    chk1("ready_idle", f_ready(sel), 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int unsigned t1, t2;
    int          gap;
    logic [7:0]  b;

    rst       = 1'b1;
    ena       = 1'b1;
    tx_data   = 8'h00;
    tx_valid0 = 1'b1;   // reset must win over a pending request
    tx_valid1 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("reset_tx0", tx0, 1'b1);
    chk1("reset_busy0", busy0, 1'b0);
    chk1("reset_tx1", tx1, 1'b1);
    chk1("reset_busy1", busy1, 1'b0);
    chk("reset_state0", 32'(dbg0), 32'(IDLE));
    chk("reset_state1", 32'(dbg1), 32'(IDLE));
    tx_valid0 = 1'b0;
    rst       = 1'b0;
    @(negedge clk);
    chk1("reset_ready0", tx_ready0, 1'b1);
    chk1("reset_ready1", tx_ready1, 1'b1);

    // Single byte, no parity.
    start_frame(0, 8'hA5, 1'b0, t1);
    check_frame(0, 8'hA5, -1, 0, -1);

    // Parity frames: 0x07 has parity 1, 0x03 has parity 0.
    start_frame(1, 8'h07, 1'b0, t1);
    check_frame(1, 8'h07, -1, 0, -1);
    start_frame(1, 8'h03, 1'b0, t1);
    check_frame(1, 8'h03, -1, 0, -1);

    // Back-to-back with tx_valid held; data bus changes during frame 1.
    start_frame(0, 8'h55, 1'b1, t1);
    tx_data = 8'hAA;
    check_frame(0, 8'h55, -1, 0, -1);
    @(posedge clk);
    t2 = cyc;
    @(negedge clk);
    set_valid(0, 1'b0);
    chk("b2b_accept_spacing", 32'(t2 - t1), 32'd41);
    check_frame(0, 8'hAA, -1, 0, -1);

    // Reset during data bit 3 of 0xFF (frame cycles 17..20).
    start_frame(0, 8'hFF, 1'b0, t1);
    build_frame(8'hFF, 1'b0);
    for (int i = 1; i <= 18; i++) begin
      if (i > 1) @(negedge clk);
      chk1("abort_tx_bit", tx0, exp_q[i-1]);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk1("abort_tx", tx0, 1'b1);
    chk1("abort_busy", busy0, 1'b0);
    chk1("abort_ready", tx_ready0, 1'b1);
    start_frame(0, 8'h00, 1'b0, t1);
    check_frame(0, 8'h00, -1, 0, -1);

    // Enable dropped for 7 cycles inside data bit 2 (frame cycles 13..16).
    start_frame(0, 8'h81, 1'b0, t1);
    check_frame(0, 8'h81, 14, 7, -1);

    // Stray request while busy must be ignored.
    start_frame(0, 8'hC3, 1'b0, t1);
    check_frame(0, 8'hC3, -1, 0, 10);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk1("ignored_req_tx", tx0, 1'b1);
      chk1("ignored_req_busy", busy0, 1'b0);
    end

    // Randomized bytes, gaps and stalls on both variants.
    for (int n = 0; n < 12; n++) begin
      int sel;
      sel = n % 2;
      b   = 8'($urandom_range(0, 255));
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
      start_frame(sel, b, 1'b0, t1);
      if ((n % 3) == 2) check_frame(sel, b, $urandom_range(2, 36), $urandom_range(1, 5), -1);
      else              check_frame(sel, b, -1, 0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pin_uart_tx.md
# pin_uart_tx

Serial transmitter that drives a single output pin from a parallel byte. The top-level wrapper presents the byte on the dedicated inputs and routes `tx` to a dedicated output. Frames are standard 8N1 (optional even parity), LSB first, at a fixed integer clocks-per-bit ratio. The block is the sending end of the board's UART link and is paired with the host-side receiver.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; must be ≥ 2.
- `PARITY_EN`, default 0: 1 inserts one even-parity bit between the data and stop bits.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `ena` input 1: 1 means run, 0 means freeze all state.
- `tx_data` input 8: byte to send; sampled only on accept.
- `tx_valid` input 1: request to send `tx_data`.
- `tx_ready` output 1: block can accept a byte this cycle.
- `tx` output 1: serial line, idle high.
- `busy` output 1: a frame is in progress.

## Operation

- FSM states: IDLE, START, DATA, PARITY, STOP.
- Accept occurs when `tx_valid && tx_ready && ena` are all high at a clock edge.
  - On accept, latch `tx_data` into the shift register, clear the bit counter and baud counter, and go to START.
- `tx_ready` = (state == IDLE) && `ena`. It is combinational from registered state.
- `busy` = (state != IDLE).
- START: `tx` = 0 for `CLKS_PER_BIT` cycles, then go to DATA.
- DATA: `tx` = shift register bit 0.
  - Each time the baud counter reaches `CLKS_PER_BIT`-1: shift right, increment the 3-bit bit counter, and reset the baud counter.
  - After bit index 7 completes, go to PARITY if `PARITY_EN`, else STOP.
- PARITY: `tx` = XOR of the latched byte (even parity) for one bit time.
  - Parity is computed at accept and held in its own flop.
- STOP: `tx` = 1 for one bit time, then go to IDLE.
- `tx_data` changing after accept has no effect on the frame in flight.
- `tx_valid` asserted while busy is ignored. It is not queued, and the requester must hold it until `tx_ready`.
- `ena` = 0 freezes the state, baud counter, bit counter and shift register. `tx` holds its current level and `tx_ready` = 0.
- Baud counter width is $clog2(`CLKS_PER_BIT`). It wraps to 0 at `CLKS_PER_BIT`-1 and never runs past it.

## Timing

- Reset values (one edge with `rst` = 1): state IDLE, `tx` = 1, `busy` = 0, `tx_ready` = 1 whenever `ena` = 1, all counters 0.
- Reset mid-frame aborts the frame. The edge after `rst` is sampled high, `tx` = 1 and the state is IDLE, with no partial stop bit.
- `rst` takes priority over `ena` and over accept.
- `tx` is driven from a flop, so there are no glitches.
- Latency: the accept edge leads to `tx` = 0 in the following cycle.
- Frame length F = (10 + `PARITY_EN`) × `CLKS_PER_BIT` cycles from the first start-bit cycle to the last stop-bit cycle.
- Back-to-back frames:
  - `tx_ready` rises in the cycle after the last stop-bit cycle.
  - The minimum accept-to-accept spacing is F + 1 cycles.
  - The line is high for exactly 1 extra idle cycle between frames.
- `busy` rises with the start bit and falls together with `tx_ready`.

## Structure

- Shared package `pin_uart_pkg`:
  - state enum `uart_state_t` (IDLE, START, DATA, PARITY, STOP);
  - constants `UART_DATA_BITS` = 8 and `UART_IDLE_LEVEL` = 1'b1.
  - The future receiver reuses this package.
- One sub-module, `uart_baud_gen`:
  - parameter `CLKS_PER_BIT`;
  - inputs `clk`, `rst`, `ena`, `clear`;
  - output `bit_done`, a one-cycle pulse on the last cycle of each bit time.
- The top of the block holds the FSM, shift register, parity flop and bit counter.

## Test plan

All scenarios use `CLKS_PER_BIT` = 4 unless stated.

1. Single byte: reset, then send 0xA5 with `PARITY_EN` = 0.
   - `tx` sequence per 4-cycle bit is 0, 1,0,1,0,0,1,0,1, 1.
   - `busy` is high for 40 cycles, then `tx_ready` = 1.
2. Parity: `PARITY_EN` = 1, send 0x07 (three ones), then 0x03.
   - Parity bit is 1 for 0x07 and 0 for 0x03.
   - Each frame is 44 cycles.
3. Back-to-back: `tx_valid` held high with 0x55 then 0xAA.
   - Second accept occurs exactly 41 cycles after the first.
   - Exactly one idle-high cycle separates the two stop/start bits.
   - `tx_data` change during frame 1 does not corrupt frame 1.
4. Reset mid-frame: send 0xFF and assert `rst` during data bit 3.
   - The next cycle has `tx` = 1, `busy` = 0, `tx_ready` = 1.
   - A subsequent 0x00 frame is sent cleanly.
5. Enable stall: drop `ena` for 7 cycles in the middle of data bit 2 of 0x81.
   - `tx` holds its level.
   - The frame completes in 40 + 7 = 47 cycles with the bits unchanged.
   - `tx_ready` = 0 while `ena` = 0.
6. Ignored request: pulse `tx_valid` with 0x3C while busy.
   - No second frame starts.
   - The line returns idle after the first frame.
